mem_stage: RTL and testbench

//  - Memory pipeline stage. Sits directly downstream of execute and consumes its *_ixmem_p1 bundle.
//  - Performs data-memory loads/stores over a req/ready/rvalid handshake.
//  - Stalls upstream while an access is outstanding; drives the *_memwb_p1 writeback bundle.

---
 rtl/mem_stage_if.sv | 17 +
 rtl/mem_stage.sv | 145 ++++++++++++++
 tb/tb_mem_stage.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage (master) and the memory (slave):
// request with write-enable, ready acceptance, rvalid read return.
interface mem_stage_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, wr, addr, wdata, input ready, rvalid, rdata);
  modport slave  (input req, wr, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results through and runs loads/stores on the dmem bus.
// Optional macro MEM_STAGE_ALIGN_CHECK_EN rejects odd-address accesses with mem_excep_p1.
//  state | meaning
//  IDLE  | accepting ALU ops and new accesses
//  REQ   | request held on the bus until ready
//  WAIT  | load accepted, waiting for rvalid
module mem_stage #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dest_reg_value_ixmem_p1,
  input  logic [2:0]        dest_reg_index_ixmem_p1,
  input  logic              dest_reg_write_valid_ixmem_p1,
  input  logic [ADDR_W-1:0] mem_addr_ixmem_p1,
  input  logic [DATA_W-1:0] mem_data_in_ixmem_p1,
  input  logic              ldst_valid_ixmem_p1,
  input  logic [1:0]        store_valid_ixmem_p1,
  output logic              mem_stall,
  mem_stage_if.master       dmem,
  output logic [2:0]        dest_reg_index_memwb_p1,
  output logic [DATA_W-1:0] dest_reg_value_memwb_p1,
  output logic              dest_reg_write_valid_memwb_p1,
  output logic              mem_excep_p1
);
  localparam int CNT_W = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        st_type;
  logic [2:0]        cap_idx;
  logic [DATA_W-1:0] cap_val;
  logic              misaligned, accept, is_store, is_stu, tmo;
  logic [2:0]        wb_idx_n;
  logic [DATA_W-1:0] wb_val_n;
  logic              wb_wv_n, excep_n;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign misaligned = mem_addr_ixmem_p1[0];
`else
  assign misaligned = 1'b0;
`endif

  assign accept    = (state == IDLE) && ldst_valid_ixmem_p1 && !misaligned;
  assign is_store  = |st_type;
  assign is_stu    = st_type[1];
  // cnt counts finished REQ/WAIT cycles, so this is the TMO_CYC-th cycle of the access
  assign tmo       = (cnt == CNT_W'(TMO_CYC - 1));
  assign mem_stall = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state == IDLE) ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = REQ;
      REQ:     if (dmem.ready) state_n = is_store ? IDLE : WAIT;
               else if (tmo) state_n = IDLE;
      WAIT:    if (dmem.rvalid || tmo) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Progress is tested before the timeout so a completion on the last cycle wins.
  always_comb begin
    wb_idx_n = '0;
    wb_val_n = '0;
    wb_wv_n  = 1'b0;
    excep_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!ldst_valid_ixmem_p1) begin
          wb_idx_n = dest_reg_index_ixmem_p1;
          wb_val_n = dest_reg_value_ixmem_p1;
          wb_wv_n  = dest_reg_write_valid_ixmem_p1;
        end else if (misaligned) begin
          excep_n = 1'b1;
        end
      end
      REQ: begin
        if (dmem.ready) begin
          if (is_stu) begin
            wb_idx_n = cap_idx;
            wb_val_n = cap_val;
            wb_wv_n  = 1'b1;
          end
        end else if (tmo) begin
          excep_n = 1'b1;
        end
      end
      WAIT: begin
        if (dmem.rvalid) begin
          wb_idx_n = cap_idx;
          wb_val_n = dmem.rdata;
          wb_wv_n  = 1'b1;
        end else if (tmo) begin
          excep_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem.req                      <= 1'b0;
      dmem.wr                       <= 1'b0;
      dmem.addr                     <= '0;
      dmem.wdata                    <= '0;
      st_type                       <= '0;
      cap_idx                       <= '0;
      cap_val                       <= '0;
      dest_reg_index_memwb_p1       <= '0;
      dest_reg_value_memwb_p1       <= '0;
      dest_reg_write_valid_memwb_p1 <= 1'b0;
      mem_excep_p1                  <= 1'b0;
    end else begin
      dmem.req                      <= (state_n == REQ);
      dest_reg_index_memwb_p1       <= wb_idx_n;
      dest_reg_value_memwb_p1       <= wb_val_n;
      dest_reg_write_valid_memwb_p1 <= wb_wv_n;
      mem_excep_p1                  <= excep_n;
      if (accept) begin
        dmem.addr  <= mem_addr_ixmem_p1;
        dmem.wdata <= mem_data_in_ixmem_p1;
        dmem.wr    <= |store_valid_ixmem_p1;
        st_type    <= store_valid_ixmem_p1;
        cap_idx    <= dest_reg_index_ixmem_p1;
        cap_val    <= dest_reg_value_ixmem_p1;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: random ops against a transaction-level model, writeback
// events checked by a scoreboard monitor, memory emulated by a delay-scripted responder.
module tb_mem_stage;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] in_val;
  logic [2:0]    in_idx;
  logic          in_wv;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_wdata;
  logic          in_ldst;
  logic [1:0]    in_st;
  logic          mem_stall;
  logic [2:0]    wb_idx;
  logic [DW-1:0] wb_val;
  logic          wb_wv;
  logic          excep;

  mem_stage_if #(.ADDR_W(AW), .DATA_W(DW)) dmem_bus ();

  mem_stage #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .dest_reg_value_ixmem_p1       (in_val),
    .dest_reg_index_ixmem_p1       (in_idx),
    .dest_reg_write_valid_ixmem_p1 (in_wv),
    .mem_addr_ixmem_p1             (in_addr),
    .mem_data_in_ixmem_p1          (in_wdata),
    .ldst_valid_ixmem_p1           (in_ldst),
    .store_valid_ixmem_p1          (in_st),
    .mem_stall                     (mem_stall),
    .dmem                          (dmem_bus),
    .dest_reg_index_memwb_p1       (wb_idx),
    .dest_reg_value_memwb_p1       (wb_val),
    .dest_reg_write_valid_memwb_p1 (wb_wv),
    .mem_excep_p1                  (excep)
  );

  typedef struct {
    bit            exc;
    logic [2:0]    idx;
    logic [DW-1:0] val;
  } wb_t;

  typedef struct {
    int            rd;
    int            vd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            wr;
  } acc_t;

  wb_t           exp_q[$];
  acc_t          acc_q[$];
  int            wb_cyc[$];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  bit            resp_en  = 1'b1;
  logic [DW-1:0] ref_mem   [256];
  logic [DW-1:0] slave_mem [256];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic int rnd_dly();
    if ($urandom_range(0, 9) < 8) return int'($urandom_range(0, 3));
    return int'($urandom_range(10, 17));
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor: every writeback or exception strobe consumes one expectation.
  initial forever begin
    wb_t e;
    @(negedge clk);
    if (wb_wv || excep) begin
      chk("strobe_exclusive", 32'(wb_wv & excep), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual=wv%0d/exc%0d idx=%0d val=%0h required=none",
                 wb_wv, excep, wb_idx, wb_val);
      end else begin
        e = exp_q.pop_front();
        chk("wb_is_excep", 32'(excep), 32'(e.exc));
        if (!e.exc) begin
          chk("wb_idx", 32'(wb_idx), 32'(e.idx));
          chk("wb_val", 32'(wb_val), 32'(e.val));
        end
      end
      wb_cyc.push_back(cyc);
    end
  end

  task automatic respond();
    acc_t a;
    int   k = 0;
    int   j = 0;
    bit   got = 1'b0;
    if (acc_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_req actual=%0h required=none", dmem_bus.addr);
      return;
    end
    a = acc_q.pop_front();
    while (!got) begin
      dmem_bus.rvalid = 1'b0;
      if (!dmem_bus.req) return;
      chk("dmem_addr", 32'(dmem_bus.addr), 32'(a.addr));
      chk("dmem_wdata", 32'(dmem_bus.wdata), 32'(a.wdata));
      chk("dmem_wr", 32'(dmem_bus.wr), 32'(a.wr));
      if (k == a.rd) begin
        dmem_bus.ready = 1'b1;
        if (a.wr) slave_mem[a.addr[7:0]] = a.wdata;
        @(negedge clk);
        dmem_bus.ready = 1'b0;
        got = 1'b1;
      end else begin
        // rvalid noise while still requesting must be ignored
        dmem_bus.rvalid = 1'($urandom_range(0, 1));
        dmem_bus.rdata  = 16'($urandom);
        @(negedge clk);
        k++;
      end
    end
    if (a.wr) return;
    while (mem_stall) begin
      if (j == a.vd) begin
        dmem_bus.rvalid = 1'b1;
        dmem_bus.rdata  = slave_mem[a.addr[7:0]];
        @(negedge clk);
        dmem_bus.rvalid = 1'b0;
        return;
      end
      @(negedge clk);
      j++;
    end
  endtask

  initial begin
    dmem_bus.ready  = 1'b0;
    dmem_bus.rvalid = 1'b0;
    dmem_bus.rdata  = '0;
    forever begin
      @(negedge clk);
      if (resp_en && dmem_bus.req) respond();
    end
  end

  // Called at a negedge with the stage idle; returns once the op has fully retired.
  task automatic issue(input bit ldst, input logic [1:0] st, input logic [2:0] idx,
                       input logic [DW-1:0] val, input bit wv, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int rd, input int vd);
    bit   mis;
    bit   is_ld;
    bit   ok;
    int   exp_stall;
    int   n;
    acc_t a;
    mis = 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    mis = ldst && addr[0];
`endif
    in_ldst = ldst; in_st = st; in_idx = idx; in_val = val; in_wv = wv;
    in_addr = addr; in_wdata = wdata;
    exp_stall = 0;
    is_ld = (st == 2'b00);
    if (!ldst) begin
      if (wv) exp_q.push_back('{1'b0, idx, val});
    end else if (mis) begin
      exp_q.push_back('{1'b1, 3'd0, 16'd0});
    end else begin
      ok = (rd + 1 <= TMO) && (!is_ld || rd + vd + 2 <= TMO);
      exp_stall = ok ? rd + 1 + (is_ld ? vd + 1 : 0) : TMO;
      a = '{rd, vd, addr, wdata, !is_ld};
      acc_q.push_back(a);
      if (!ok) exp_q.push_back('{1'b1, 3'd0, 16'd0});
      else if (is_ld) exp_q.push_back('{1'b0, idx, ref_mem[addr[7:0]]});
      else begin
        ref_mem[addr[7:0]] = wdata;
        if (st[1]) exp_q.push_back('{1'b0, idx, val});
      end
    end
    @(negedge clk);
    n = 0;
    while (mem_stall && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    chk("req_low_when_idle", 32'(dmem_bus.req), 32'd0);
  endtask

  task automatic bubble();
    issue(1'b0, 2'b00, 3'd0, 16'd0, 1'b0, 16'd0, 16'd0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [1:0]    rs;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = 16'(i * 32'h1357) ^ 16'hA5A5;
      slave_mem[i] = ref_mem[i];
    end
    in_ldst = 1'b0; in_st = 2'b00; in_idx = 3'd0; in_val = '0; in_wv = 1'b0;
    in_addr = '0; in_wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_req", 32'(dmem_bus.req), 32'd0);
    chk("rst_wr", 32'(dmem_bus.wr), 32'd0);
    chk("rst_addr", 32'(dmem_bus.addr), 32'd0);
    chk("rst_wdata", 32'(dmem_bus.wdata), 32'd0);
    chk("rst_wb_idx", 32'(wb_idx), 32'd0);
    chk("rst_wb_val", 32'(wb_val), 32'd0);
    chk("rst_wb_wv", 32'(wb_wv), 32'd0);
    chk("rst_excep", 32'(excep), 32'd0);
    rst = 1'b0;

    // ALU pass-through, then a load with stall of 4 and a held follow-on ALU op
    issue(1'b0, 2'b00, 3'd3, 16'h1234, 1'b1, 16'd0, 16'd0, 0, 0);
    issue(1'b1, 2'b00, 3'd5, 16'h0000, 1'b1, 16'h0010, 16'd0, 0, 2);
    issue(1'b0, 2'b00, 3'd1, 16'h5555, 1'b1, 16'd0, 16'd0, 0, 0);
    bubble();
    @(negedge clk);
    chk("held_op_retire_gap", 32'(wb_cyc[wb_cyc.size()-1] - wb_cyc[wb_cyc.size()-2]), 32'd1);

    // STU and plain store with delayed ready, store_valid=11, timeouts and last-cycle progress
    issue(1'b1, 2'b10, 3'd2, 16'h0042, 1'b1, 16'h0040, 16'hAAAA, 3, 0);
    issue(1'b1, 2'b01, 3'd2, 16'h0042, 1'b1, 16'h0040, 16'hAAAA, 3, 0);
    issue(1'b1, 2'b11, 3'd4, 16'h0077, 1'b1, 16'h0044, 16'h1111, 1, 0);
    issue(1'b1, 2'b00, 3'd6, 16'h0000, 1'b0, 16'h0044, 16'd0, 0, 0);
    issue(1'b1, 2'b00, 3'd7, 16'h0000, 1'b1, 16'h0050, 16'd0, 20, 0);
    issue(1'b1, 2'b01, 3'd7, 16'h0000, 1'b0, 16'h0052, 16'h2222, 14, 0);
    issue(1'b1, 2'b00, 3'd1, 16'h0000, 1'b1, 16'h0052, 16'd0, 0, 13);
    issue(1'b1, 2'b00, 3'd1, 16'h0000, 1'b1, 16'h0052, 16'd0, 0, 14);
    issue(1'b1, 2'b00, 3'd3, 16'h0000, 1'b1, 16'h0013, 16'd0, 0, 0);

    // Reset while waiting for rvalid; the late rvalid lands in IDLE
    resp_en = 1'b0;
    in_ldst = 1'b1; in_st = 2'b00; in_idx = 3'd6; in_addr = 16'h0020; in_wv = 1'b1;
    @(negedge clk);
    dmem_bus.ready = 1'b1;
    in_ldst = 1'b0; in_wv = 1'b0;
    @(negedge clk);
    dmem_bus.ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata  = 16'hDEAD;
    chk("rstw_stall", 32'(mem_stall), 32'd0);
    chk("rstw_req", 32'(dmem_bus.req), 32'd0);
    chk("rstw_wv", 32'(wb_wv), 32'd0);
    chk("rstw_val", 32'(wb_val), 32'd0);
    @(negedge clk);
    dmem_bus.rvalid = 1'b0;
    chk("rstw_late_rvalid_stall", 32'(mem_stall), 32'd0);
    resp_en = 1'b1;
    issue(1'b1, 2'b00, 3'd6, 16'h0000, 1'b1, 16'h0020, 16'd0, 1, 1);

    for (int i = 0; i < 150; i++) begin
      ra = {8'h00, 8'($urandom)};
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      if ($urandom_range(0, 9) != 0) ra[0] = 1'b0;
`endif
      rs = 2'($urandom_range(0, 3));
      issue(($urandom_range(0, 3) != 0), rs, 3'($urandom_range(0, 7)), 16'($urandom),
            1'($urandom_range(0, 1)), ra, 16'($urandom), rnd_dly(), rnd_dly());
    end
    bubble();
    repeat (5) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("acc_q_drained", 32'(acc_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
